compacc_frame: RTL and testbench



---
 rtl/compmult_pkg.sv | 25 ++
 rtl/vld_delay.sv | 39 +++
 rtl/compacc_frame.sv | 171 +++++++++++++++++
 tb/tb_compacc_frame.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compmult_pkg.sv
// ---------------------------------------------------------------------------
// compmult_pkg
//
// Shared definitions for the complex-multiplier datapath and its consumers.
//   N_DEF        : default operand width of the upstream multiplier
//   MULT_LAT_DEF : default multiplier latency (operand sample -> valid product)
//   acc_width()  : width needed to sum frame_len products of 2N bits each
//   out_state_t  : state of a one-entry valid/ready result register
// ---------------------------------------------------------------------------
package compmult_pkg;

  localparam int N_DEF        = 8;
  localparam int MULT_LAT_DEF = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // A 2N-bit product summed frame_len times grows by clog2(frame_len) bits.
  function automatic int acc_width(input int n, input int frame_len);
    return 2 * n + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/vld_delay.sv
// ---------------------------------------------------------------------------
// vld_delay
//
// DEPTH-stage shift register that realigns an operand-side valid strobe with
// the output of a pipelined datapath of the same latency.
//   clk   in   clock
//   reset in   asynchronous, active-high; clears every tap
//   din   in   strobe entering the pipeline
//   dout  out  strobe after DEPTH clock edges (last tap)
// ---------------------------------------------------------------------------
module vld_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] taps_reg;
  logic [DEPTH-1:0] taps_next;

  // Shift toward the MSB; works for DEPTH == 1 as well.
  always_comb begin
    taps_next    = taps_reg << 1;
    taps_next[0] = din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps_reg <= '0;
    end else begin
      taps_reg <= taps_next;
    end
  end

  assign dout = taps_reg[DEPTH-1];

endmodule

// File: rtl/compacc_frame.sv
// ---------------------------------------------------------------------------
// compacc_frame
//
// Sums the complex product stream of the pipelined multiplier over frames of
// FRAME_LEN valid products and hands each frame sum to a consumer through a
// one-entry valid/ready result register.
//   clk        in   clock
//   reset      in   asynchronous, active-high; clears all state
//   in_valid   in   multiplier samples a valid operand set this cycle
//   prod_r/i   in   2N-bit signed multiplier product (real / imaginary)
//   flush      in   discard the partial frame (output side untouched)
//   acc_r/i    out  ACC_W-bit signed frame sum held in the result register
//   out_valid  out  result register holds an unconsumed frame sum
//   out_ready  in   consumer takes the result this cycle
//   overrun    out  sticky: a completed frame was dropped (cleared by reset)
//   frame_cnt  out  products accumulated so far in the current frame
// ---------------------------------------------------------------------------
module compacc_frame
  import compmult_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int FRAME_LEN = 16,
  parameter int MULT_LAT  = MULT_LAT_DEF,
  parameter int ACC_W     = acc_width(N, FRAME_LEN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [2*N-1:0]        prod_r,
  input  logic signed [2*N-1:0]        prod_i,
  input  logic                         flush,
  output logic signed [ACC_W-1:0]      acc_r,
  output logic signed [ACC_W-1:0]      acc_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  output logic [$clog2(FRAME_LEN)-1:0] frame_cnt
);

  localparam int                CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

  // ------------------------------------------------------------------------
  // Valid realignment: the strobe travels alongside the operands so that
  // vld_d is high exactly in the cycle prod_* carries that operand's product.
  // ------------------------------------------------------------------------
  logic vld_d;

  vld_delay #(
    .DEPTH (MULT_LAT)
  ) u_vld_delay (
    .clk   (clk),
    .reset (reset),
    .din   (in_valid),
    .dout  (vld_d)
  );

  // ------------------------------------------------------------------------
  // Frame accumulator
  // ------------------------------------------------------------------------
  logic signed [ACC_W-1:0] prod_r_ext;
  logic signed [ACC_W-1:0] prod_i_ext;
  logic signed [ACC_W-1:0] base_r;
  logic signed [ACC_W-1:0] base_i;
  logic signed [ACC_W-1:0] sum_r_add;
  logic signed [ACC_W-1:0] sum_i_add;
  logic signed [ACC_W-1:0] sum_r_reg;
  logic signed [ACC_W-1:0] sum_i_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    last_prod;
  logic                    complete;

  assign prod_r_ext = {{(ACC_W - 2*N){prod_r[2*N-1]}}, prod_r};
  assign prod_i_ext = {{(ACC_W - 2*N){prod_i[2*N-1]}}, prod_i};

  // The first product of a frame overwrites whatever the previous frame (or
  // a flushed partial frame) left behind, so no explicit clear is needed.
  assign base_r    = (cnt_reg == '0) ? '0 : sum_r_reg;
  assign base_i    = (cnt_reg == '0) ? '0 : sum_i_reg;
  assign sum_r_add = base_r + prod_r_ext;
  assign sum_i_add = base_i + prod_i_ext;

  assign last_prod = (cnt_reg == CNT_LAST);
  // Flush wins over a product arriving in the same cycle.
  assign complete  = vld_d && !flush && last_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      sum_r_reg <= '0;
      sum_i_reg <= '0;
    end else if (flush) begin
      cnt_reg <= '0;
    end else if (vld_d) begin
      sum_r_reg <= sum_r_add;
      sum_i_reg <= sum_i_add;
      cnt_reg   <= last_prod ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  assign frame_cnt = cnt_reg;

  // ------------------------------------------------------------------------
  // Result register control. The slot counts as free when it is empty or
  // when the consumer drains it in the same cycle a frame completes, which
  // keeps a continuously-ready consumer at one result per frame without gaps.
  // ------------------------------------------------------------------------
  out_state_t state_reg;
  out_state_t state_next;
  logic       load;
  logic       drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (complete) begin
          state_next = FULL;
          load       = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          if (out_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  assign out_valid = (state_reg == FULL);

  // The held sum only changes on a load, so it stays stable while FULL and
  // keeps the last delivered value while EMPTY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
      acc_i <= '0;
    end else if (load) begin
      acc_r <= sum_r_add;
      acc_i <= sum_i_add;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_compacc_frame.sv
// ---------------------------------------------------------------------------
// tb_compacc_frame
//
// Drives two accumulators (FRAME_LEN 4 and 16) from one operand stream that
// passes through a behavioural 4-cycle complex multiplier. A frame-level
// model predicts the outputs of both every cycle; directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_compacc_frame;

  localparam int N    = 8;
  localparam int ML   = 4;
  localparam int FL4  = 4;
  localparam int FL16 = 16;
  localparam int AW4  = 2*N + 2;
  localparam int AW16 = 2*N + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic signed [N-1:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic signed [2*N-1:0] prod_r, prod_i;
  logic signed [2*N-1:0] pipe_r [ML];
  logic signed [2*N-1:0] pipe_i [ML];

  logic signed [AW4-1:0]  acc_r4, acc_i4;
  logic signed [AW16-1:0] acc_r16, acc_i16;
  logic ov4, ov16, ovr4, ovr16;
  logic [1:0] cnt4;
  logic [3:0] cnt16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic signed [2*N-1:0] mul_re(input logic signed [N-1:0] ar, ai, br, bi);
    int v;
    v = int'(ar) * int'(br) - int'(ai) * int'(bi);
    return (2*N)'(v);
  endfunction

  function automatic logic signed [2*N-1:0] mul_im(input logic signed [N-1:0] ar, ai, br, bi);
    int v;
    v = int'(ar) * int'(bi) + int'(ai) * int'(br);
    return (2*N)'(v);
  endfunction

  // Behavioural upstream multiplier: product of operands sampled at edge k
  // is visible after edge k+ML-1.
  always @(posedge clk) begin
    pipe_r[0] <= mul_re(a_r, a_i, b_r, b_i);
    pipe_i[0] <= mul_im(a_r, a_i, b_r, b_i);
    for (int j = 1; j < ML; j++) begin
      pipe_r[j] <= pipe_r[j-1];
      pipe_i[j] <= pipe_i[j-1];
    end
  end

  assign prod_r = pipe_r[ML-1];
  assign prod_i = pipe_i[ML-1];

  compacc_frame #(.N(N), .FRAME_LEN(FL4), .MULT_LAT(ML)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .prod_r(prod_r), .prod_i(prod_i),
    .flush(flush), .acc_r(acc_r4), .acc_i(acc_i4), .out_valid(ov4),
    .out_ready(out_ready), .overrun(ovr4), .frame_cnt(cnt4));

  compacc_frame #(.N(N), .FRAME_LEN(FL16), .MULT_LAT(ML)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .prod_r(prod_r), .prod_i(prod_i),
    .flush(flush), .acc_r(acc_r16), .acc_i(acc_i16), .out_valid(ov16),
    .out_ready(out_ready), .overrun(ovr16), .frame_cnt(cnt16));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model (index 0: FL4, 1: FL16) ------------
  longint m_sum_r [2];
  longint m_sum_i [2];
  longint m_res_r [2];
  longint m_res_i [2];
  int     m_cnt   [2];
  bit     m_full  [2];
  bit     m_ovr   [2];
  bit     sch_v   [8];
  longint sch_r   [8];
  longint sch_i   [8];
  int     cyc = 0;

  function automatic int flen(input int k);
    return (k == 0) ? FL4 : FL16;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_sum_r[k] = 0; m_sum_i[k] = 0; m_res_r[k] = 0; m_res_i[k] = 0;
      m_cnt[k] = 0; m_full[k] = 0; m_ovr[k] = 0;
    end
    for (int s = 0; s < 8; s++) begin
      sch_v[s] = 0; sch_r[s] = 0; sch_i[s] = 0;
    end
  endtask

  // One clock edge for instance k: a product (if one lands now) joins the
  // running frame; a finished frame goes to the slot if it is free.
  task automatic model_edge(input int k, input bit v, input longint pr, input longint pi);
    bit done;
    done = 0;
    if (flush) begin
      m_cnt[k] = 0;
    end else if (v) begin
      if (m_cnt[k] == 0) begin
        m_sum_r[k] = pr; m_sum_i[k] = pi;
      end else begin
        m_sum_r[k] += pr; m_sum_i[k] += pi;
      end
      m_cnt[k]++;
      if (m_cnt[k] == flen(k)) begin
        done = 1;
        m_cnt[k] = 0;
        if (!m_full[k] || out_ready) begin
          m_res_r[k] = m_sum_r[k]; m_res_i[k] = m_sum_i[k]; m_full[k] = 1;
        end else begin
          m_ovr[k] = 1;
        end
      end
    end
    if (!done && m_full[k] && out_ready) m_full[k] = 0;
  endtask

  initial begin : model
    int slot, s2;
    bit v;
    longint pr, pi;
    model_clear();
    forever begin
      @(posedge clk);
      if (reset) begin
        model_clear();
      end else begin
        slot = cyc % 8;
        v = sch_v[slot]; pr = sch_r[slot]; pi = sch_i[slot];
        sch_v[slot] = 0;
        if (in_valid) begin
          s2 = (cyc + ML) % 8;
          sch_v[s2] = 1;
          sch_r[s2] = longint'(mul_re(a_r, a_i, b_r, b_i));
          sch_i[s2] = longint'(mul_im(a_r, a_i, b_r, b_i));
        end
        for (int k = 0; k < 2; k++) model_edge(k, v, pr, pi);
      end
      cyc++;
    end
  end

  // ---------------- per-cycle comparison ----------------------------------
  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      chk("out_valid4", longint'(ov4), longint'(m_full[0]));
      chk("overrun4", longint'(ovr4), longint'(m_ovr[0]));
      chk("frame_cnt4", longint'(cnt4), longint'(m_cnt[0]));
      chk("acc_r4", longint'(acc_r4), m_res_r[0]);
      chk("acc_i4", longint'(acc_i4), m_res_i[0]);
      chk("out_valid16", longint'(ov16), longint'(m_full[1]));
      chk("overrun16", longint'(ovr16), longint'(m_ovr[1]));
      chk("frame_cnt16", longint'(cnt16), longint'(m_cnt[1]));
      chk("acc_r16", longint'(acc_r16), m_res_r[1]);
      chk("acc_i16", longint'(acc_i16), m_res_i[1]);
      if (ov4 && out_ready)
        $display("take fl4  acc=(%0d,%0d) t=%0t", acc_r4, acc_i4, $time);
      if (ov16 && out_ready)
        $display("take fl16 acc=(%0d,%0d) t=%0t", acc_r16, acc_i16, $time);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic step(input bit iv, input int ar, input int ai, input int br, input int bi,
                      input bit fl, input bit rdy);
    @(negedge clk);
    in_valid = iv;
    if (iv) begin
      a_r = N'(ar); a_i = N'(ai); b_r = N'(br); b_i = N'(bi);
    end else begin
      a_r = N'($urandom); a_i = N'($urandom); b_r = N'($urandom); b_i = N'($urandom);
    end
    flush = fl;
    out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  initial begin : main
    int gv  [7] = '{1, 0, 0, 1, 1, 0, 1};
    int gar [7] = '{2, 0, 0, 3, -1, 0, 0};
    int gai [7] = '{1, 0, 0, 0, 2, 0, -2};
    int gbr [7] = '{1, 0, 0, 2, 4, 0, 3};
    int gbi [7] = '{1, 0, 0, -1, 0, 0, 5};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset out_valid", longint'(ov4), 0);
    chk("reset acc_r", longint'(acc_r4), 0);
    chk("reset frame_cnt", longint'(cnt4), 0);
    chk("reset overrun", longint'(ovr4), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic frame: prod=(-5,10) four times, first in_valid at edge 0.
    for (int i = 0; i < 9; i++) begin
      step(i < 4, 1, 2, 3, 4, 0, 0);
      if (i == 6) chk("basic early out_valid", longint'(ov4), 0);
      if (i == 7) begin
        chk("basic out_valid", longint'(ov4), 1);
        chk("basic acc_r", longint'(acc_r4), -20);
        chk("basic acc_i", longint'(acc_i4), 40);
        chk("basic overrun", longint'(ovr4), 0);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    chk("basic drained", longint'(ov4), 0);

    // Extreme values on the 16-product instance.
    step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 21; i++) begin
      step(i < 16, -128, 0, -128, 0, 0, 1);
      if (i == 7) chk("extreme fl4 acc_r", longint'(acc_r4), 65536);
      if (i == 19) begin
        chk("extreme out_valid", longint'(ov16), 1);
        chk("extreme acc_r", longint'(acc_r16), 262144);
        chk("extreme acc_i", longint'(acc_i16), 0);
      end
    end

    // Gapped stream: valid products (1,3)+(6,-3)+(-4,8)+(10,-6) = (13,2).
    for (int i = 0; i < 11; i++) begin
      step(gv[i % 7] != 0 && i < 7, gar[i % 7], gai[i % 7], gbr[i % 7], gbi[i % 7], 0, 0);
      if (i == 5 || i == 6) chk("gap frame_cnt hold", longint'(cnt4), 1);
      if (i == 9) chk("gap early out_valid", longint'(ov4), 0);
      if (i == 10) begin
        chk("gap out_valid", longint'(ov4), 1);
        chk("gap acc_r", longint'(acc_r4), 13);
        chk("gap acc_i", longint'(acc_i4), 2);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back: frame sums 4, 8, 12; consumer takes each result in the
    // very cycle the next one completes.
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(i < 12, i / 4 + 1, 0, 1, 0, 0, (i == 7 || i == 11 || i == 15));
      if (i == 7) chk("b2b first acc_r", longint'(acc_r4), 4);
      if (i == 9) chk("b2b held out_valid", longint'(ov4), 1);
      if (i == 11) begin
        chk("b2b second acc_r", longint'(acc_r4), 8);
        chk("b2b second out_valid", longint'(ov4), 1);
        chk("b2b overrun", longint'(ovr4), 0);
      end
      if (i == 15) begin
        chk("b2b third acc_r", longint'(acc_r4), 12);
        chk("b2b third acc_i", longint'(acc_i4), 0);
        chk("b2b third overrun", longint'(ovr4), 0);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    chk("b2b drained", longint'(ov4), 0);

    // Flush at frame_cnt=2 (also discarding a product landing with it),
    // then four products of (1,1).
    for (int i = 0; i < 15; i++) begin
      if (i < 3) step(1, 7, 0, 1, 0, i == 6, 0);
      else step(i >= 7 && i <= 10, 1, 0, 1, 1, i == 6, 0);
      if (i == 5) chk("flush cnt before", longint'(cnt4), 2);
      if (i == 6) chk("flush cnt after", longint'(cnt4), 0);
      if (i == 13) chk("flush early out_valid", longint'(ov4), 0);
      if (i == 14) begin
        chk("flush out_valid", longint'(ov4), 1);
        chk("flush acc_r", longint'(acc_r4), 4);
        chk("flush acc_i", longint'(acc_i4), 4);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);

    // Backpressure: two frames (8 then 12) with no consumer.
    for (int i = 0; i < 12; i++) begin
      step(i < 8, 1, 0, (i < 4) ? 2 : 3, 0, 0, 0);
      if (i == 7) chk("bp first acc_r", longint'(acc_r4), 8);
      if (i == 10) chk("bp overrun before", longint'(ovr4), 0);
      if (i == 11) begin
        chk("bp overrun", longint'(ovr4), 1);
        chk("bp held out_valid", longint'(ov4), 1);
        chk("bp held acc_r", longint'(acc_r4), 8);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    chk("bp drained", longint'(ov4), 0);
    chk("bp overrun sticky", longint'(ovr4), 1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 6; i++) step(i < 2, 5, 0, 1, 0, 0, 0);
    chk("pre-reset frame_cnt", longint'(cnt4), 2);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", longint'(ov4), 0);
    chk("async reset overrun", longint'(ovr4), 0);
    chk("async reset frame_cnt", longint'(cnt4), 0);
    chk("async reset acc_r", longint'(acc_r4), 0);
    chk("async reset acc_i", longint'(acc_i4), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(i < 4, 1, 0, 2, -1, 0, 0);
      if (i == 7) begin
        chk("post-reset out_valid", longint'(ov4), 1);
        chk("post-reset acc_r", longint'(acc_r4), 8);
        chk("post-reset acc_i", longint'(acc_i4), -4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
